// File: rtl/npc_pkg.sv
// Shared NPC core constants and the fetch-stage state encoding.
package npc_pkg;

   localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      HALT
   } ifu_state_t;

endpackage

// File: rtl/ifu_fetch_pc_reg.sv
// Fetch PC register: reset / redirect / sequential-advance mux.
// Without IFU_MISALIGN_CHECK_EN the low two PC bits are forced to zero on every load.
module ifu_pc_reg #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_redirect,
   input  logic            advance,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Redirect beats the sequential increment when both arrive together.
   always_comb begin
      pc_d = pc_q;
      if (load_redirect) begin
         pc_d = redirect_pc;
      end else if (advance) begin
         pc_d = pc_q + XLEN'(4);
      end
`ifndef IFU_MISALIGN_CHECK_EN
      pc_d[1:0] = 2'b00;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, redirect/drop handling, halt.
// Optional macro IFU_MISALIGN_CHECK_EN adds inst_misalign and traps misaligned redirects.
module ifu_fetch
   import npc_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = NPC_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
`ifdef IFU_MISALIGN_CHECK_EN
   output logic            inst_misalign,
`endif
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt
);

   ifu_state_t      state_q, state_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic [XLEN-1:0] pc;
   logic            load_redirect;
   logic            advance;
   logic            redir_ok;
`ifdef IFU_MISALIGN_CHECK_EN
   logic            misalign_q, misalign_d;
`endif

   ifu_pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_redirect (load_redirect),
      .advance       (advance),
      .redirect_pc   (redirect_pc),
      .pc            (pc)
   );

   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif
      redir_ok      = redirect_valid &&
                      (state_q == REQ || state_q == WAIT || state_q == HOLD);
      load_redirect = redir_ok;
      advance       = (state_q == HOLD) && inst_ready;

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_req_ready) begin
               state_d = WAIT;
               // A redirect alongside the handshake leaves a stale response in flight.
               drop_d  = redir_ok;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (drop_q || redir_ok) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  inst_d    = imem_rsp_data;
                  inst_pc_d = pc;
                  state_d   = HOLD;
               end
            end else if (redir_ok) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
`ifdef IFU_MISALIGN_CHECK_EN
            if (inst_ready && (halt || misalign_q)) begin
`else
            if (inst_ready && halt) begin
`endif
               state_d = HALT;
            end else if (redir_ok || inst_ready) begin
               state_d = REQ;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase

`ifdef IFU_MISALIGN_CHECK_EN
      if (state_d == REQ) begin
         misalign_d = 1'b0;
      end
      // A misaligned target is never fetched; a NOP is handed to decode instead.
      if (redir_ok && (redirect_pc[1:0] != 2'b00) && (state_d != HALT)) begin
         state_d    = HOLD;
         drop_d     = 1'b0;
         inst_d     = XLEN'(NOP_INST);
         inst_pc_d  = redirect_pc;
         misalign_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         drop_q    <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
`ifdef IFU_MISALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign imem_req_valid = (state_q == REQ);
   assign imem_addr      = pc;
   assign inst_valid     = (state_q == HOLD);
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
   assign inst_misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch (build with IFU_MISALIGN_CHECK_EN for the trap path).
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
   logic        inst_misalign;
`endif

   int errors = 0;
   int checks = 0;

   // imem model: answers one cycle after each accepted request
   bit          auto_rsp = 1'b1;
   bit          ovr = 1'b0;
   logic [31:0] ovr_data = '0;
   localparam logic [31:0] KEY = 32'h1234_5678;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
`ifdef IFU_MISALIGN_CHECK_EN
      .inst_misalign  (inst_misalign),
`endif
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt)
   );

   task automatic cycle();
      bit          hs;
      logic [31:0] a;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_addr;
      @(posedge clk);
      #1;
      if (auto_rsp) begin
         imem_rsp_valid = hs;
         imem_rsp_data  = hs ? (ovr ? ovr_data : (a ^ KEY)) : 32'h0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 00000000", inst); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 00000000", inst_pc); end
      checks++; if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr: got %h want 80000000", imem_addr); end
      rst_n = 1'b1;
      cycle();
      $display("reset released: req_valid=%b addr=%h", imem_req_valid, imem_addr);
   endtask

   task automatic test_stream();
      logic [31:0] a;
      for (int k = 0; k < 3; k++) begin
         a = 32'h8000_0000 + 32'(4 * k);
         checks++; if (imem_req_valid !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL stream_req%0d: got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_addr, a); end
         cycle();
         checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL stream_wait%0d: got req=%b iv=%b want 0 0", k, imem_req_valid, inst_valid); end
         cycle();
         checks++; if (inst_valid !== 1'b1 || inst_pc !== a || inst !== (a ^ KEY)) begin errors++; $display("FAIL stream_inst%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, inst_valid, inst_pc, inst, a, a ^ KEY); end
         $display("fetch pc=%h inst=%h", inst_pc, inst);
         cycle();
      end
   endtask

   task automatic test_stall();
      inst_ready = 1'b0;
      cycle();
      cycle();
      for (int k = 0; k < 5; k++) begin
         checks++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || inst_pc !== 32'h8000_000C || inst !== (32'h8000_000C ^ KEY)) begin
            errors++; $display("FAIL stall_hold%0d: got iv=%b rv=%b pc=%h i=%h want 1 0 8000000c %h", k, inst_valid, imem_req_valid, inst_pc, inst, 32'h8000_000C ^ KEY);
         end
         cycle();
      end
      inst_ready = 1'b1;
      cycle();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0010) begin errors++; $display("FAIL stall_next: got v=%b a=%h want 1 80000010", imem_req_valid, imem_addr); end
      $display("stall released: next addr=%h", imem_addr);
   endtask

   task automatic test_redirect_wait();
      auto_rsp = 1'b0;
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      cycle();
      redirect_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_wait: got iv=%b rv=%b want 0 0", inst_valid, imem_req_valid); end
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      cycle();
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      auto_rsp = 1'b1;
      checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0100) begin errors++; $display("FAIL rw_req: got iv=%b rv=%b a=%h want 0 1 80000100", inst_valid, imem_req_valid, imem_addr); end
      cycle();
      cycle();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst !== (32'h8000_0100 ^ KEY)) begin errors++; $display("FAIL rw_inst: got v=%b pc=%h i=%h want 1 80000100 %h", inst_valid, inst_pc, inst, 32'h8000_0100 ^ KEY); end
      $display("redirect in WAIT: fetch pc=%h inst=%h", inst_pc, inst);
      cycle();
   endtask

   task automatic test_redirect_req();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0008;
      cycle();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL rr_nohs: got v=%b a=%h want 1 80000008", imem_req_valid, imem_addr); end
      imem_req_ready = 1'b1;
      redirect_pc = 32'h8000_0200;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL rr_drop: got iv=%b rv=%b a=%h want 0 1 80000200", inst_valid, imem_req_valid, imem_addr); end
      cycle();
      cycle();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0200 || inst !== (32'h8000_0200 ^ KEY)) begin errors++; $display("FAIL rr_inst: got v=%b pc=%h i=%h want 1 80000200 %h", inst_valid, inst_pc, inst, 32'h8000_0200 ^ KEY); end
      $display("redirect with handshake: fetch pc=%h", inst_pc);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
      cycle();
      redirect_valid = 1'b0;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0300) begin errors++; $display("FAIL rr_hold: got v=%b a=%h want 1 80000300", imem_req_valid, imem_addr); end
   endtask

   task automatic test_halt();
      int bad;
      ovr = 1'b1; ovr_data = 32'h0010_0073;
      cycle();
      cycle();
      ovr = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0073) begin errors++; $display("FAIL halt_inst: got v=%b i=%h want 1 00100073", inst_valid, inst); end
      halt = 1'b1;
      cycle();
      halt = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) bad++;
         cycle();
         redirect_valid = 1'b0;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL halt_quiet: got %0d active cycles want 0", bad); end
      $display("halted: 50 cycles observed");
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL halt_rst_idle: got rv=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
      cycle();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL halt_restart: got v=%b a=%h want 1 80000000", imem_req_valid, imem_addr); end
   endtask

   task automatic test_wrap();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      cycle();
      cycle();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst: got v=%b pc=%h want 1 fffffffc", inst_valid, inst_pc); end
      cycle();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got v=%b a=%h want 1 00000000", imem_req_valid, imem_addr); end
      $display("wrap: next addr=%h", imem_addr);
   endtask

   task automatic test_misalign();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
      cycle();
      redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0102 || inst_misalign !== 1'b1) begin
         errors++; $display("FAIL mis_trap: got rv=%b iv=%b i=%h pc=%h m=%b want 0 1 00000013 80000102 1", imem_req_valid, inst_valid, inst, inst_pc, inst_misalign);
      end
      imem_req_ready = 1'b1;
      cycle();
      checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mis_halt: got rv=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
`else
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0100) begin errors++; $display("FAIL mis_align: got v=%b a=%h want 1 80000100", imem_req_valid, imem_addr); end
      imem_req_ready = 1'b1;
`endif
      $display("misaligned redirect: addr=%h inst_valid=%b", imem_addr, inst_valid);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_wait();
      test_redirect_req();
      test_halt();
      test_wrap();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
